// File: rtl/parser_ingress_scheduler.sv
// Round-robin ingress arbiter feeding the parser_unit_1 chain; issues at most one
// packet per cycle and tags each one with its requester id until it leaves the chain.
module parser_ingress_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int MSG_W      = 2048,
    parameter int PIPE_DEPTH = 10,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*MSG_W-1:0]          req_message,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [MSG_W-1:0]                  message,
    output logic [143:0]                      req_key_in,
    output logic [11:0]                       offset_in,
    output logic [11:0]                       action2_offset_old,
    output logic                              control_in,
    output logic                              msg_valid,
    output logic                              resp_valid,
    output logic [ID_W-1:0]                   resp_id,
    output logic [$clog2(PIPE_DEPTH+2)-1:0]   inflight,
    output logic [31:0]                       grant_count
);

    localparam int CNT_W = $clog2(PIPE_DEPTH + 2);

    logic [ID_W-1:0]       r_last;
    logic [MSG_W-1:0]      r_message;
    logic                  r_msgValid;
    logic [ID_W-1:0]       r_issueId;
    logic [PIPE_DEPTH-1:0] r_tagValid;
    logic [ID_W-1:0]       r_tagId [PIPE_DEPTH];
    logic [CNT_W-1:0]      r_inflight;
    logic [31:0]           r_grantCount;

    int                    w_bestDist;
    logic [ID_W-1:0]       w_grantId;
    logic                  w_grant;
    logic [MSG_W-1:0]      w_grantMsg;

    // Pick the valid requester closest to last+1 going round the ring.
    always_comb begin
        w_bestDist = NUM_REQ;
        w_grantId  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j] && ((j + NUM_REQ - 1 - int'(r_last)) % NUM_REQ) < w_bestDist) begin
                w_bestDist = (j + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
                w_grantId  = ID_W'(j);
            end
        end
    end

    assign w_grant   = enable & reset & (|req_valid);
    assign req_ready = w_grant ? (NUM_REQ'(1) << w_grantId) : '0;

    always_comb begin
        w_grantMsg = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == w_grantId) begin
                w_grantMsg = req_message[j*MSG_W +: MSG_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_message  <= '0;
            r_msgValid <= 1'b0;
            r_issueId  <= '0;
            r_last     <= ID_W'(NUM_REQ - 1);
        end else begin
            r_msgValid <= w_grant;
            if (w_grant) begin
                r_message <= w_grantMsg;
                r_issueId <= w_grantId;
                r_last    <= w_grantId;
            end
        end
    end

    // Tags shadow the parser chain so resp_valid lines up with its last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tagValid <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_tagId[k] <= '0;
            end
        end else begin
            r_tagValid <= {r_tagValid[PIPE_DEPTH-2:0], r_msgValid};
            r_tagId[0] <= r_issueId;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_tagId[k] <= r_tagId[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight   <= '0;
            r_grantCount <= '0;
        end else begin
            if (w_grant && !r_tagValid[PIPE_DEPTH-1]) begin
                r_inflight <= r_inflight + CNT_W'(1);
            end else if (!w_grant && r_tagValid[PIPE_DEPTH-1]) begin
                r_inflight <= r_inflight - CNT_W'(1);
            end
            if (w_grant) begin
                r_grantCount <= r_grantCount + 32'd1;
            end
        end
    end

    assign message            = r_message;
    assign msg_valid          = r_msgValid;
    assign req_key_in         = r_message[MSG_W-1-96 -: 144];
    assign offset_in          = 12'd96;
    assign action2_offset_old = 12'd112;
    assign control_in         = 1'b0;
    assign resp_valid         = r_tagValid[PIPE_DEPTH-1];
    assign resp_id            = r_tagId[PIPE_DEPTH-1];
    assign inflight           = r_inflight;
    assign grant_count        = r_grantCount;

endmodule
